nic_host_agent: RTL and testbench
=================================

Name: nic_host_agent

Overview:
Host-side sequencer that sits directly upstream of a mesh node's NIC. It drives the NIC's CPU register interface (addr/d_in/d_out/nicEn/nicEnWR) in place of a processor. Host logic pushes outgoing packets into a TX queue; the agent polls NIC status, writes packets into the NIC output channel and drains the NIC input channel into an RX queue. One instance exists per mesh node; instances feed nic_0_0 … nic_3_0.

Parameters:
PACKET_WIDTH, 64, packet width in bits (matches the NIC)
TXQ_DEPTH, 4, TX queue entries, power of 2, ≥2
RXQ_DEPTH, 4, RX queue entries, power of 2, ≥2
CNT_WIDTH, 16, width of the sent/received packet counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
tx_valid  in  1  host offers a packet for transmission
tx_ready  out  1  TX queue not full; transfer occurs when tx_valid && tx_ready
tx_data  in  PACKET_WIDTH  packet to transmit
rx_valid  out  1  RX queue not empty
rx_ready  in  1  host accepts the head of the RX queue
rx_data  out  PACKET_WIDTH  head of the RX queue
addr  out  2  NIC register select
d_in  out  PACKET_WIDTH  write data to the NIC
d_out  in  PACKET_WIDTH  read data from the NIC
nicEn  out  1  NIC access strobe
nicEnWR  out  1  1 = write, 0 = read; qualified by nicEn
tx_count  out  CNT_WIDTH  packets written to the NIC, wraps
rx_count  out  CNT_WIDTH  packets read from the NIC, wraps
busy  out  1  FSM not in IDLE

Behaviour:
- NIC register map: 0 = input-channel buffer (read); 1 = input-channel status (bit0=1: packet present); 2 = output-channel buffer (write); 3 = output-channel status (bit0=1: buffer full).
- NIC timing: a write is committed at the clock edge where nicEn=1 and nicEnWR=1. A read has 1-cycle latency: d_out is valid in the cycle after nicEn=1 and nicEnWR=0.
- All outputs are registered. At reset: addr=0, d_in=0, nicEn=0, nicEnWR=0, both queues empty (tx_ready=1, rx_valid=0, rx_data=0), counters=0, busy=0, FSM=IDLE, priority=RX.
- nicEn is high for exactly one cycle per access. The agent never issues back-to-back accesses without a WAIT state.
- FSM states:
  - IDLE: if priority=RX, go to POLL_IN when RX queue is not full, else to POLL_OUT when TX queue is non-empty. If priority=TX, try those two in the opposite order. If neither condition holds, stay in IDLE.
  - POLL_IN: read addr 1, then go to WAIT_IN.
  - WAIT_IN: if d_out[0]=1, go to RD_IN; otherwise go to IDLE.
  - RD_IN: read addr 0, then go to WAIT_RD.
  - WAIT_RD: push d_out into the RX queue, increment rx_count, go to IDLE.
  - POLL_OUT: read addr 3, then go to WAIT_OUT.
  - WAIT_OUT: if d_out[0]=0, go to WR_OUT; otherwise go to IDLE.
  - WR_OUT: addr=2, d_in=TX head, nicEnWR=1; pop the TX queue, increment tx_count, go to IDLE.
- Priority toggles every time the FSM leaves IDLE, giving RX/TX round-robin fairness.
- POLL_IN is entered only while the RX queue has a free slot, so the WAIT_RD push can never overflow. An RX pop by the host during the push cycle is legal.
- The TX head is stable from POLL_OUT through WR_OUT, because only WR_OUT pops the TX queue.
- Queues are FIFOs with a 1-cycle push-to-visible latency. Simultaneous push and pop on a full queue: tx_ready=0 blocks the push, and the pop proceeds. Simultaneous push and pop on an empty queue: the pushed entry appears the next cycle.
- Counters wrap modulo 2^CNT_WIDTH.
- Reset asserted mid-access aborts the access; the next cycle shows the reset values and any in-flight packet is dropped.

Decomposition:
- Shared package nic_host_pkg holds:
  - register-address constants NIC_ADDR_IN_BUF=0, NIC_ADDR_IN_STAT=1, NIC_ADDR_OUT_BUF=2, NIC_ADDR_OUT_STAT=3;
  - status-bit index STAT_BIT=0;
  - the FSM state enum.
- One sub-module, host_sync_fifo (parameters WIDTH, DEPTH), instantiated twice: TX queue and RX queue.

Test Plan:
- Reset: hold reset=0 for 3 cycles with tx_valid=1 -> nicEn=0, tx_ready=1, rx_valid=0, tx_count=0, rx_count=0, busy=0.
- Single TX: push 64'hC0DE_0000_0000_0001 with NIC out-status 0 -> sequence read addr3, write addr2 with d_in=that value and nicEnWR=1; tx_count=1 after 3 FSM cycles from POLL_OUT.
- TX backpressure: NIC out-status bit0=1 for 20 cycles, push 5 packets -> tx_ready=0 after the 4th push, no writes to addr2; release status -> 4 writes in push order.
- RX drain: NIC in-status=1 with buffer values 0xA1, 0xA2, 0xA3, 0xA4, 0xA5 and rx_ready=0 -> 4 reads of addr0, rx_count=4, no 5th POLL_IN; pulse rx_ready once -> 0xA5 is fetched and appears after 0xA4.
- Fairness: both directions saturated -> the access sequence alternates POLL_IN / POLL_OUT; tx_count and rx_count differ by ≤1 after 100 cycles.
- Mid-access reset: assert reset during WAIT_RD -> the next cycle shows rx_valid=0, rx_count=0, nicEn=0, and no RX push occurs.

Source files
------------

// File: rtl/nic_host_pkg.sv
// Shared definitions for the NIC host agent: NIC register map, status bit
// position and the sequencer state encoding.
package nic_host_pkg;

  localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'd0;
  localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'd1;
  localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'd2;
  localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'd3;

  localparam int unsigned STAT_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL_IN,
    ST_WAIT_IN,
    ST_RD_IN,
    ST_WAIT_RD,
    ST_POLL_OUT,
    ST_WAIT_OUT,
    ST_WR_OUT
  } state_e;

endpackage

// File: rtl/host_sync_fifo.sv
// Small synchronous FIFO used for the host-side TX and RX queues.
// Ports: clk, reset (sync, active-low), push/push_data (ignored when full),
//        pop (ignored when empty), full, empty, head (zero while empty).
module host_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Gate the head so an empty queue presents zero without resetting storage.
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage write; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nic_host_agent.sv
// Host-side sequencer driving a mesh NIC's CPU register port. Polls NIC
// status, moves TX-queue packets into the NIC output channel and drains the
// NIC input channel into the RX queue, alternating RX/TX priority.
// Ports: clk, reset (sync, active-low); host TX stream tx_valid/tx_ready/
//        tx_data; host RX stream rx_valid/rx_ready/rx_data; NIC register
//        port addr/d_in/d_out/nicEn/nicEnWR; tx_count/rx_count packet
//        counters (wrapping); busy (sequencer not idle).
module nic_host_agent
  import nic_host_pkg::*;
#(
  parameter int unsigned PACKET_WIDTH = 64,
  parameter int unsigned TXQ_DEPTH    = 4,
  parameter int unsigned RXQ_DEPTH    = 4,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic [PACKET_WIDTH-1:0] tx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [PACKET_WIDTH-1:0] rx_data,
  output logic [1:0]              addr,
  output logic [PACKET_WIDTH-1:0] d_in,
  input  logic [PACKET_WIDTH-1:0] d_out,
  output logic                    nicEn,
  output logic                    nicEnWR,
  output logic [CNT_WIDTH-1:0]    tx_count,
  output logic [CNT_WIDTH-1:0]    rx_count,
  output logic                    busy
);

  state_e                  state;
  state_e                  state_d;
  logic                    prio_tx;
  logic                    prio_tx_d;
  logic [1:0]              addr_d;
  logic [PACKET_WIDTH-1:0] d_in_d;
  logic                    en_d;
  logic                    wr_d;
  logic                    tx_full;
  logic                    tx_empty;
  logic                    rx_full;
  logic                    rx_empty;
  logic [PACKET_WIDTH-1:0] tx_head;
  logic                    tx_pop;
  logic                    rx_push;

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
  assign tx_pop   = (state == ST_WR_OUT);
  assign rx_push  = (state == ST_WAIT_RD);

  // Outgoing packets from the host; popped only in WR_OUT so the head is
  // stable across the whole poll/write sequence.
  host_sync_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(TXQ_DEPTH)) u_txq (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (tx_pop),
    .full      (tx_full),
    .empty     (tx_empty),
    .head      (tx_head)
  );

  // Incoming packets to the host; d_out carries read data in WAIT_RD.
  host_sync_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(RXQ_DEPTH)) u_rxq (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (d_out),
    .pop       (rx_ready),
    .full      (rx_full),
    .empty     (rx_empty),
    .head      (rx_data)
  );

  // Next state, priority and the NIC access to present in the next state.
  always_comb begin
    state_d   = state;
    prio_tx_d = prio_tx;
    addr_d    = addr;
    d_in_d    = '0;
    en_d      = 1'b0;
    wr_d      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!prio_tx) begin
          if (!rx_full)       state_d = ST_POLL_IN;
          else if (!tx_empty) state_d = ST_POLL_OUT;
        end else begin
          if (!tx_empty)      state_d = ST_POLL_OUT;
          else if (!rx_full)  state_d = ST_POLL_IN;
        end
        if (state_d != ST_IDLE) prio_tx_d = !prio_tx;
      end
      ST_POLL_IN:  state_d = ST_WAIT_IN;
      ST_WAIT_IN:  state_d = d_out[STAT_BIT] ? ST_RD_IN : ST_IDLE;
      ST_RD_IN:    state_d = ST_WAIT_RD;
      ST_WAIT_RD:  state_d = ST_IDLE;
      ST_POLL_OUT: state_d = ST_WAIT_OUT;
      ST_WAIT_OUT: state_d = d_out[STAT_BIT] ? ST_IDLE : ST_WR_OUT;
      ST_WR_OUT:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // Access registers are loaded on entry so nicEn is high for exactly the
    // cycle spent in an access state.
    case (state_d)
      ST_POLL_IN: begin
        en_d   = 1'b1;
        addr_d = NIC_ADDR_IN_STAT;
      end
      ST_RD_IN: begin
        en_d   = 1'b1;
        addr_d = NIC_ADDR_IN_BUF;
      end
      ST_POLL_OUT: begin
        en_d   = 1'b1;
        addr_d = NIC_ADDR_OUT_STAT;
      end
      ST_WR_OUT: begin
        en_d   = 1'b1;
        wr_d   = 1'b1;
        addr_d = NIC_ADDR_OUT_BUF;
        d_in_d = tx_head;
      end
      default: ;
    endcase
  end

  // State, NIC port and counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      prio_tx  <= 1'b0;
      addr     <= '0;
      d_in     <= '0;
      nicEn    <= 1'b0;
      nicEnWR  <= 1'b0;
      busy     <= 1'b0;
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      state   <= state_d;
      prio_tx <= prio_tx_d;
      addr    <= addr_d;
      d_in    <= d_in_d;
      nicEn   <= en_d;
      nicEnWR <= wr_d;
      busy    <= (state_d != ST_IDLE);
      if (tx_pop)  tx_count <= tx_count + CNT_WIDTH'(1);
      if (rx_push) rx_count <= rx_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_nic_host_agent.sv
// Directed bench for nic_host_agent with a behavioural NIC register model.
module tb_nic_host_agent;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [63:0] tx_data = '0;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [63:0] rx_data;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out = '0;
  logic        nic_en;
  logic        nic_en_wr;
  logic [15:0] tx_count;
  logic [15:0] rx_count;
  logic        busy;

  always #5 clk = ~clk;

  nic_host_agent dut (
    .clk      (clk),
    .reset    (reset),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .addr     (addr),
    .d_in     (d_in),
    .d_out    (d_out),
    .nicEn    (nic_en),
    .nicEnWR  (nic_en_wr),
    .tx_count (tx_count),
    .rx_count (rx_count),
    .busy     (busy)
  );

  // NIC model state: input channel holds in_vals[in_idx .. in_lim-1].
  logic        out_full = 1'b0;
  int          in_idx = 0;
  int          in_lim = 0;
  logic [63:0] in_vals [256];
  int          wr_n = 0;
  int          stat1_n = 0;
  int          poll_n = 0;
  logic [63:0] wr_log [64];
  logic [1:0]  wr_prev [64];
  logic [1:0]  poll_log [256];
  logic [1:0]  last_addr = 2'd0;

  always @(posedge clk) begin
    if (nic_en) begin
      if (nic_en_wr) begin
        if (addr == 2'd2) begin
          if (wr_n < 64) begin
            wr_log[6'(wr_n)]  = d_in;
            wr_prev[6'(wr_n)] = last_addr;
          end
          wr_n = wr_n + 1;
        end
      end else begin
        case (addr)
          2'd0: begin
            d_out <= in_vals[8'(in_idx)];
            in_idx = in_idx + 1;
          end
          2'd1: begin
            d_out <= {63'b0, (in_idx < in_lim)};
            stat1_n = stat1_n + 1;
            if (poll_n < 256) poll_log[8'(poll_n)] = addr;
            poll_n = poll_n + 1;
          end
          2'd3: begin
            d_out <= {63'b0, out_full};
            if (poll_n < 256) poll_log[8'(poll_n)] = addr;
            poll_n = poll_n + 1;
          end
          default: d_out <= '0;
        endcase
      end
      last_addr = addr;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_tx(input logic [63:0] v);
    tx_data  = v;
    tx_valid = 1'b1;
    for (int k = 0; k < 50 && !tx_ready; k++) tick(1);
    chk("push_rdy", 64'(tx_ready), 64'd1);
    tick(1);
    tx_valid = 1'b0;
  endtask

  logic [63:0] pv [4];
  int wr0;
  int base;
  int s1;
  int p0;
  int diff;
  int viol;

  initial begin
    for (int i = 0; i < 256; i++) in_vals[i] = 64'hBEEF_0000_0000_0000 | 64'(i);

    // Reset held with a TX offer pending.
    reset    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 64'hDEAD;
    tick(3);
    chk("rst_en",      64'(nic_en),   64'd0);
    chk("rst_txrdy",   64'(tx_ready), 64'd1);
    chk("rst_rxvld",   64'(rx_valid), 64'd0);
    chk("rst_rxdata",  rx_data,       64'd0);
    chk("rst_txcnt",   64'(tx_count), 64'd0);
    chk("rst_rxcnt",   64'(rx_count), 64'd0);
    chk("rst_busy",    64'(busy),     64'd0);
    chk("rst_addr",    64'(addr),     64'd0);
    tx_valid = 1'b0;
    reset    = 1'b1;
    tick(2);

    // Single TX: poll addr3 then write addr2.
    push_tx(64'hC0DE_0000_0000_0001);
    for (int k = 0; k < 30 && !(nic_en && !nic_en_wr && addr == 2'd3); k++) tick(1);
    chk("tx1_poll", 64'(nic_en && !nic_en_wr && addr == 2'd3), 64'd1);
    tick(1);
    chk("tx1_wait_en", 64'(nic_en), 64'd0);
    tick(1);
    chk("tx1_wr_addr", 64'(addr), 64'd2);
    chk("tx1_wr_en",   64'({nic_en, nic_en_wr}), 64'd3);
    chk("tx1_wr_data", d_in, 64'hC0DE_0000_0000_0001);
    chk("tx1_cnt_early", 64'(tx_count), 64'd0);
    tick(1);
    chk("tx1_cnt",  64'(tx_count), 64'd1);
    chk("tx1_en_off", 64'(nic_en), 64'd0);
    chk("tx1_nwr",  64'(wr_n), 64'd1);
    chk("tx1_log",  wr_log[0], 64'hC0DE_0000_0000_0001);
    chk("tx1_prev", 64'(wr_prev[0]), 64'd3);

    // TX backpressure: NIC output buffer full.
    out_full = 1'b1;
    wr0 = wr_n;
    for (int i = 0; i < 4; i++) pv[i] = 64'h1111_0000_0000_0000 + 64'(i + 1);
    for (int i = 0; i < 4; i++) push_tx(pv[i]);
    chk("bp_full", 64'(tx_ready), 64'd0);
    tx_data  = 64'h1111_0000_0000_0005;
    tx_valid = 1'b1;
    tick(20);
    chk("bp_block", 64'(tx_ready), 64'd0);
    chk("bp_nowr",  64'(wr_n), 64'(wr0));
    tx_valid = 1'b0;
    out_full = 1'b0;
    for (int k = 0; k < 100 && tx_count != 16'd5; k++) tick(1);
    chk("bp_cnt", 64'(tx_count), 64'd5);
    tick(10);
    chk("bp_total", 64'(wr_n), 64'(wr0 + 4));
    for (int i = 0; i < 4; i++) chk("bp_order", wr_log[6'(wr0 + i)], pv[i]);

    // RX drain with host not accepting.
    base = in_idx;
    for (int i = 0; i < 5; i++) in_vals[8'(base + i)] = 64'hA1 + 64'(i);
    in_lim = base + 5;
    for (int k = 0; k < 100 && rx_count != 16'd4; k++) tick(1);
    s1 = stat1_n;
    tick(20);
    chk("rx_cnt4",    64'(rx_count), 64'd4);
    chk("rx_reads",   64'(in_idx - base), 64'd4);
    chk("rx_no_poll", 64'(stat1_n), 64'(s1));
    chk("rx_vld",     64'(rx_valid), 64'd1);
    chk("rx_head0",   rx_data, 64'hA1);
    chk("rx_idle",    64'(busy), 64'd0);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    for (int k = 0; k < 50 && rx_count != 16'd5; k++) tick(1);
    chk("rx_cnt5", 64'(rx_count), 64'd5);
    tick(2);
    for (int i = 0; i < 4; i++) begin
      chk("rx_head", rx_data, 64'hA2 + 64'(i));
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
    end
    chk("rx_empty", 64'(rx_valid), 64'd0);

    // Fairness: both directions saturated from a fresh reset.
    in_lim   = in_idx + 1000;
    rx_ready = 1'b1;
    tx_data  = 64'h5A5A;
    tx_valid = 1'b1;
    reset    = 1'b0;
    tick(1);
    reset    = 1'b1;
    p0       = poll_n;
    tick(100);
    diff = int'(tx_count) - int'(rx_count);
    chk("fair_diff", 64'(diff <= 1 && diff >= -1), 64'd1);
    chk("fair_prog", 64'(tx_count > 16'd5), 64'd1);
    chk("fair_first", 64'(poll_log[8'(p0)]), 64'd1);
    viol = 0;
    for (int i = p0; i + 1 < poll_n && i < 254; i++)
      if (poll_log[8'(i)] == poll_log[8'(i + 1)]) viol++;
    chk("fair_alt", 64'(viol), 64'd0);

    // Reset asserted while the RX read data is in flight.
    tx_valid = 1'b0;
    for (int k = 0; k < 50 && !(nic_en && !nic_en_wr && addr == 2'd0); k++) tick(1);
    chk("mr_rdin", 64'(nic_en && !nic_en_wr && addr == 2'd0), 64'd1);
    tick(1);
    chk("mr_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    tick(1);
    chk("mr_rxvld", 64'(rx_valid), 64'd0);
    chk("mr_rxcnt", 64'(rx_count), 64'd0);
    chk("mr_txcnt", 64'(tx_count), 64'd0);
    chk("mr_en",    64'(nic_en), 64'd0);
    chk("mr_busy0", 64'(busy), 64'd0);
    reset = 1'b1;
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
